mdio_master: RTL and testbench

Parametrised MDIO (IEEE 802.3 Clause 22) management master. Accepts a 32-bit frame word on a start strobe and serialises it onto MDC/MDIO with a configurable MDC divider and preamble length. Turns the bus around for reads, captures the 16-bit register value and flags a missing PHY response. Sits between the management register block and the PHY pads; the block's dedicated tester drives its front-end ports.

---
 rtl/mdio_pkg.sv | 45 ++++
 rtl/mdc_gen.sv | 44 ++++
 rtl/mdio_master.sv | 161 ++++++++++++++++
 tb/tb_mdio_master.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause 22 MDIO master.
package mdio_pkg;

    typedef enum logic [2:0] {IDLE, PREAMBLE, HDR, TA, DATA, DONE} mdio_state_e;

    localparam logic [1:0] ST_VALID = 2'b01;
    localparam logic [1:0] OP_WR    = 2'b01;
    localparam logic [1:0] OP_RD    = 2'b10;

    localparam int ST_MSB    = 31;
    localparam int ST_LSB    = 30;
    localparam int OP_MSB    = 29;
    localparam int OP_LSB    = 28;
    localparam int PHYAD_MSB = 27;
    localparam int PHYAD_LSB = 23;
    localparam int REGAD_MSB = 22;
    localparam int REGAD_LSB = 18;
    localparam int TA_MSB    = 17;
    localparam int TA_LSB    = 16;
    localparam int WDATA_MSB = 15;
    localparam int WDATA_LSB = 0;

    localparam int HDR_BITS  = 14;
    localparam int TA_BITS   = 2;
    localparam int DATA_BITS = 16;

    function automatic mdio_state_e next_seg(input mdio_state_e s);
        case (s)
            PREAMBLE: next_seg = HDR;
            HDR:      next_seg = TA;
            TA:       next_seg = DATA;
            default:  next_seg = DONE;
        endcase
    endfunction

    function automatic logic [5:0] seg_len(input mdio_state_e s);
        case (s)
            HDR:     seg_len = 6'(HDR_BITS);
            TA:      seg_len = 6'(TA_BITS);
            DATA:    seg_len = 6'(DATA_BITS);
            default: seg_len = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/mdc_gen.sv
// MDC divider: each MDIO bit is 2*MDC_DIV clk cycles, low half first.
module mdc_gen #(
    parameter int MDC_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic bit_start_o,
    output logic mdc_rise_o,
    output logic mdc_o
);
    localparam int CW = $clog2(2 * MDC_DIV + 1);
    localparam logic [CW-1:0] TOP  = CW'(2 * MDC_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(MDC_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mdc_q, mdc_d;

    // Down-counter: terminal count 0 marks the start of a bit, HALF the rising edge.
    always_comb begin
        bit_start_o = en_i && (cnt_q == '0);
        mdc_rise_o  = en_i && (cnt_q == HALF);
        mdc_d       = en_i && (cnt_q != '0) && (cnt_q <= HALF);
        if (!en_i)
            cnt_d = '0;
        else if (cnt_q == '0)
            cnt_d = TOP;
        else
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    assign mdc_o = mdc_q;

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO master: serialises a 32-bit frame word, turns the bus around for reads.
//   state    | meaning
//   IDLE     | waiting for mdio_start
//   PREAMBLE | sending PREAMBLE_LEN ones
//   HDR      | sending ST/OP/PHYAD/REGAD
//   TA       | turnaround: driven on writes, released and checked on reads
//   DATA     | 16 data bits out (write) or in (read)
//   DONE     | single-cycle data_rdy pulse
module mdio_master
    import mdio_pkg::*;
#(
    parameter int MDC_DIV      = 4,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdio_start,
    input  logic [31:0] t_data,
    input  logic        mdio_in,
    output logic [15:0] rd_data,
    output logic        data_rdy,
    output logic        rd_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_oe,
    output logic        mdio_out
);
    mdio_state_e state_q, state_d, seg_sel;
    logic [5:0]  bit_cnt_q, bit_cnt_d, cnt_sel;
    logic [31:0] frame_q, frame_d;
    logic [15:0] rd_shift_q, rd_shift_d, rd_data_q, rd_data_d;
    logic        is_rd_q, is_rd_d, ta_err_q, ta_err_d;
    logic        busy_q, busy_d, data_rdy_q, data_rdy_d, rd_err_q, rd_err_d;
    logic        oe_q, oe_d, out_q, out_d, drive_en;
    logic        bit_start, mdc_rise;

    mdc_gen #(.MDC_DIV(MDC_DIV)) u_mdc_gen (
        .clk         (clk),
        .reset       (reset),
        .en_i        (busy_q),
        .bit_start_o (bit_start),
        .mdc_rise_o  (mdc_rise),
        .mdc_o       (mdc)
    );

    // bit_cnt holds the bits of the current segment not yet put on the bus.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        rd_shift_d = rd_shift_q;
        rd_data_d  = rd_data_q;
        is_rd_d    = is_rd_q;
        ta_err_d   = ta_err_q;
        busy_d     = busy_q;
        oe_d       = oe_q;
        out_d      = out_q;
        data_rdy_d = 1'b0;
        rd_err_d   = 1'b0;
        seg_sel    = state_q;
        cnt_sel    = bit_cnt_q;
        drive_en   = 1'b1;

        case (state_q)
            IDLE: begin
                if (mdio_start) begin
                    if (t_data[ST_MSB:ST_LSB] != ST_VALID) begin
                        state_d    = DONE;
                        data_rdy_d = 1'b1;
                        rd_err_d   = 1'b1;
                    end else begin
                        frame_d  = t_data;
                        is_rd_d  = (t_data[OP_MSB:OP_LSB] == OP_RD);
                        ta_err_d = 1'b0;
                        busy_d   = 1'b1;
                        if (PREAMBLE_LEN == 0) begin
                            state_d   = HDR;
                            bit_cnt_d = 6'(HDR_BITS);
                        end else begin
                            state_d   = PREAMBLE;
                            bit_cnt_d = 6'(PREAMBLE_LEN);
                        end
                    end
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (mdc_rise && is_rd_q) begin
                    if (state_q == TA && bit_cnt_q == 6'd0)
                        ta_err_d = mdio_in;
                    if (state_q == DATA)
                        rd_shift_d = {rd_shift_q[14:0], mdio_in};
                end
                if (bit_start) begin
                    if (bit_cnt_q == 6'd0) begin
                        seg_sel = next_seg(state_q);
                        cnt_sel = seg_len(seg_sel);
                        state_d = seg_sel;
                    end
                    if (seg_sel == DONE) begin
                        busy_d     = 1'b0;
                        oe_d       = 1'b0;
                        out_d      = 1'b0;
                        data_rdy_d = 1'b1;
                        rd_err_d   = is_rd_q && ta_err_q;
                        if (is_rd_q)
                            rd_data_d = rd_shift_q;
                    end else begin
                        bit_cnt_d = cnt_sel - 6'd1;
                        drive_en  = !(is_rd_q && (seg_sel == TA || seg_sel == DATA));
                        oe_d      = drive_en;
                        if (seg_sel == PREAMBLE) begin
                            out_d = 1'b1;
                        end else begin
                            out_d   = drive_en & frame_q[31];
                            frame_d = {frame_q[30:0], 1'b0};
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            rd_shift_q <= '0;
            rd_data_q  <= '0;
            is_rd_q    <= 1'b0;
            ta_err_q   <= 1'b0;
            busy_q     <= 1'b0;
            data_rdy_q <= 1'b0;
            rd_err_q   <= 1'b0;
            oe_q       <= 1'b0;
            out_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            rd_shift_q <= rd_shift_d;
            rd_data_q  <= rd_data_d;
            is_rd_q    <= is_rd_d;
            ta_err_q   <= ta_err_d;
            busy_q     <= busy_d;
            data_rdy_q <= data_rdy_d;
            rd_err_q   <= rd_err_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign data_rdy = data_rdy_q;
    assign rd_err   = rd_err_q;
    assign busy     = busy_q;
    assign mdio_oe  = oe_q;
    assign mdio_out = out_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: default instance plus an MDC_DIV=1, PREAMBLE_LEN=0 instance.
module tb_mdio_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start, mdio_in;
    logic [31:0] t_data;
    logic [15:0] rd_data;
    logic        data_rdy, rd_err, busy, mdc, mdio_oe, mdio_out;

    logic        start_f, mdio_in_f;
    logic [31:0] t_data_f;
    logic [15:0] rd_data_f;
    logic        data_rdy_f, rd_err_f, busy_f, mdc_f, mdio_oe_f, mdio_out_f;

    int n_checks = 0;
    int n_errors = 0;

    mdio_master dut (
        .clk(clk), .reset(reset), .mdio_start(start), .t_data(t_data), .mdio_in(mdio_in),
        .rd_data(rd_data), .data_rdy(data_rdy), .rd_err(rd_err), .busy(busy),
        .mdc(mdc), .mdio_oe(mdio_oe), .mdio_out(mdio_out)
    );

    mdio_master #(.MDC_DIV(1), .PREAMBLE_LEN(0)) dut_f (
        .clk(clk), .reset(reset), .mdio_start(start_f), .t_data(t_data_f), .mdio_in(mdio_in_f),
        .rd_data(rd_data_f), .data_rdy(data_rdy_f), .rd_err(rd_err_f), .busy(busy_f),
        .mdc(mdc_f), .mdio_oe(mdio_oe_f), .mdio_out(mdio_out_f)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // phy: 0 = nobody drives (mdio_in=1), 1 = PHY answers TA=Z/0 and data 0x1234
    task automatic do_frame(input logic [31:0] word, input int phy,
                            output logic [63:0] obs_out, output logic [63:0] obs_oe,
                            output int lat, output int bad,
                            output logic err_at_rdy, output logic pulse_ok);
        logic [15:0] pd;
        logic        cur_out, cur_oe;
        int          i, p;
        pd = 16'h1234;
        obs_out = '0; obs_oe = '0; lat = -1; bad = 0;
        err_at_rdy = 1'b0; pulse_ok = 1'b0; cur_out = 1'b0; cur_oe = 1'b0;
        mdio_in = 1'b1;
        t_data  = word;
        start   = 1'b1;
        tick();
        start  = 1'b0;
        t_data = 32'h2FE5946D;
        for (int j = 1; j <= 600; j++) begin
            tick();
            if (data_rdy) begin
                lat = j;
                err_at_rdy = rd_err;
                if (busy || mdc || mdio_oe) bad++;
                break;
            end
            i = (j - 1) / 8;
            p = (j - 1) % 8;
            if (!busy) bad++;
            if (mdc !== (p >= 4)) bad++;
            if (p == 0) begin
                cur_out = mdio_out;
                cur_oe  = mdio_oe;
                if (i < 64) begin
                    obs_out[63-i] = mdio_out;
                    obs_oe[63-i]  = mdio_oe;
                end
                if (phy == 1 && i == 47)
                    mdio_in = 1'b0;
                else if (phy == 1 && i >= 48 && i < 64)
                    mdio_in = pd[63-i];
                else
                    mdio_in = 1'b1;
            end else if (mdio_out !== cur_out || mdio_oe !== cur_oe) begin
                bad++;
            end
        end
        if (lat > 0) begin
            tick();
            pulse_ok = !data_rdy && !rd_err;
        end
        mdio_in = 1'b1;
    endtask

    initial begin
        logic [63:0] o_out, o_oe;
        logic [31:0] f_out, f_oe;
        int          lat, bad;
        logic        e_rdy, p_ok;

        reset = 1'b1; start = 1'b0; t_data = '0; mdio_in = 1'b1;
        start_f = 1'b0; t_data_f = '0; mdio_in_f = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_vals", {rd_data, data_rdy, rd_err, busy, mdc, mdio_oe, mdio_out}, '0);
        check("reset_vals_f", {rd_data_f, data_rdy_f, rd_err_f, busy_f, mdc_f, mdio_oe_f, mdio_out_f}, '0);

        // read with responding PHY
        do_frame(32'h608A0000, 1, o_out, o_oe, lat, bad, e_rdy, p_ok);
        check("rd_oe", o_oe, 64'hFFFFFFFF_FFFC0000);
        check("rd_hdr", o_out & 64'hFFFFFFFF_FFFC0000, 64'hFFFFFFFF_60880000);
        check("rd_lat", 64'(lat), 64'd513);
        check("rd_proto", 64'(bad), 64'd0);
        check("rd_err", {63'd0, e_rdy}, 64'd0);
        check("rd_pulse", {63'd0, p_ok}, 64'd1);
        check("rd_data", {48'd0, rd_data}, 64'h1234);

        // reset mid-preamble, held two cycles
        t_data = 32'h508ABEEF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_vals", {rd_data, data_rdy, rd_err, busy, mdc, mdio_oe, mdio_out}, '0);
        tick();
        reset = 1'b0;
        bad = 0;
        for (int j = 0; j < 600; j++) begin
            tick();
            if (data_rdy || busy || mdc || mdio_oe) bad++;
        end
        check("rst_quiet", 64'(bad), 64'd0);

        // write with defaults
        do_frame(32'h508ABEEF, 0, o_out, o_oe, lat, bad, e_rdy, p_ok);
        check("wr_out", o_out, 64'hFFFFFFFF_508ABEEF);
        check("wr_oe", o_oe, 64'hFFFFFFFF_FFFFFFFF);
        check("wr_lat", 64'(lat), 64'd513);
        check("wr_proto", 64'(bad), 64'd0);
        check("wr_err", {63'd0, e_rdy}, 64'd0);
        check("wr_rd_data", {48'd0, rd_data}, 64'h0);

        // read with no PHY
        do_frame(32'h608A0000, 0, o_out, o_oe, lat, bad, e_rdy, p_ok);
        check("nophy_lat", 64'(lat), 64'd513);
        check("nophy_err", {63'd0, e_rdy}, 64'd1);
        check("nophy_data", {48'd0, rd_data}, 64'hFFFF);
        check("nophy_pulse", {63'd0, p_ok}, 64'd1);

        // invalid ST
        t_data = 32'h2FE5946D; start = 1'b1;
        tick();
        start = 1'b0;
        check("inv_pulse", {61'd0, data_rdy, rd_err, busy}, 64'b110);
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (data_rdy || busy || mdc || mdio_oe) bad++;
        end
        check("inv_quiet", 64'(bad), 64'd0);
        check("inv_rd_data", {48'd0, rd_data}, 64'hFFFF);

        // fast instance: MDC_DIV=1, PREAMBLE_LEN=0
        t_data_f = 32'h508A0001; start_f = 1'b1;
        tick();
        start_f = 1'b0; t_data_f = 32'hFFFFFFFF;
        lat = -1; bad = 0; e_rdy = 1'b0; f_out = '0; f_oe = '0;
        for (int j = 1; j <= 100; j++) begin
            tick();
            if (data_rdy_f) begin
                lat = j;
                e_rdy = rd_err_f;
                break;
            end
            if (mdc_f !== ((j - 1) % 2 == 1)) bad++;
            if ((j - 1) % 2 == 0 && (j - 1) / 2 < 32) begin
                f_out[31-(j-1)/2] = mdio_out_f;
                f_oe[31-(j-1)/2]  = mdio_oe_f;
            end
            if (j == 20) begin
                start_f = 1'b1;
                t_data_f = 32'h608A0000;
            end
            if (j == 21) start_f = 1'b0;
        end
        check("fast_out", {32'd0, f_out}, 64'h508A0001);
        check("fast_oe", {32'd0, f_oe}, 64'hFFFFFFFF);
        check("fast_lat", 64'(lat), 64'd65);
        check("fast_mdc", 64'(bad), 64'd0);
        check("fast_err", {63'd0, e_rdy}, 64'd0);
        tick();
        check("fast_after", {62'd0, data_rdy_f, busy_f}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
